gpu_rect_writer: RTL

GPU_RECT_WRITER -- requirements
Module: gpu_rect_writer

---
 rtl/gpu_pkg.sv | 43 ++++
 rtl/gpu_pixel_buf.sv | 24 ++
 rtl/gpu_rect_writer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gpu_pkg.sv
// Shared definitions for the rectangle writer: register map, CTRL fields,
// draw modes and engine state type.
package gpu_pkg;

   localparam logic [3:0] REG_X      = 4'd0;
   localparam logic [3:0] REG_Y      = 4'd1;
   localparam logic [3:0] REG_COLOR  = 4'd2;
   localparam logic [3:0] REG_W      = 4'd3;
   localparam logic [3:0] REG_H      = 4'd4;
   localparam logic [3:0] REG_CTRL   = 4'd5;
   localparam logic [3:0] REG_KEY    = 4'd6;
   localparam logic [3:0] REG_STATUS = 4'd7;
   localparam logic [3:0] REG_PP     = 4'd8;

   localparam int CTRL_START    = 0;
   localparam int CTRL_MODE_LSB = 1;
   localparam int CTRL_SWAP     = 3;

   typedef enum logic [1:0] {
      MODE_FILL = 2'd0,
      MODE_COPY = 2'd1,
      MODE_KEY  = 2'd2
   } mode_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ROW,
      ST_NEXT_ROW,
      ST_DONE
   } state_t;

   function automatic logic [31:0] be_merge(input logic [31:0] cur,
                                            input logic [31:0] wd,
                                            input logic [3:0]  be);
      logic [31:0] res;
      res = cur;
      for (int i = 0; i < 4; i++)
         if (be[i]) res[i*8 +: 8] = wd[i*8 +: 8];
      return res;
   endfunction

endpackage

// File: rtl/gpu_pixel_buf.sv
// Local pixel source buffer: byte-maskable write port, registered read port
// with one cycle of latency.
module gpu_pixel_buf #(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [2:0]    wbe,
   input  logic [23:0]   wdata,
   input  logic [AW-1:0] raddr,
   output logic [23:0]   rdata
);

   logic [23:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      for (int b = 0; b < 3; b++)
         if (we && wbe[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/gpu_rect_writer.sv
// Rectangle fill/copy engine writing 24-bit pixels into a ping/pong framebuffer,
// with a small register file and vsync-aligned buffer swap.
//
//   state       | meaning
//   ST_IDLE     | waiting for CTRL start
//   ST_SETUP    | latch geometry, clip, check errors, prime buffer read
//   ST_ROW      | emit (or key-skip) one pixel per accepted beat
//   ST_NEXT_ROW | advance row bookkeeping, prime first pixel of next row
//   ST_DONE     | one-cycle completion pulse
module gpu_rect_writer
   import gpu_pkg::*;
#(
   parameter int H_DISP    = 1024,
   parameter int V_DISP    = 600,
   parameter int ADDR_W    = 21,
   parameter int BUF_DEPTH = 256,
   parameter int FB0_BASE  = 0,
   parameter int FB1_BASE  = 'h100000
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       reg_we,
   input  logic [$clog2(BUF_DEPTH):0] reg_addr,
   input  logic [3:0]                 reg_be,
   input  logic [31:0]                reg_wdata,
   output logic [31:0]                reg_rdata,
   output logic                       wr_valid,
   output logic [ADDR_W-1:0]          wr_addr,
   output logic [31:0]                wr_data,
   input  logic                       wr_ready,
   input  logic                       vsync,
   output logic [ADDR_W-1:0]          disp_base,
   output logic                       busy,
   output logic                       done
);

   localparam int BAW = $clog2(BUF_DEPTH);
   localparam logic [ADDR_W-1:0] FB0 = ADDR_W'(FB0_BASE);
   localparam logic [ADDR_W-1:0] FB1 = ADDR_W'(FB1_BASE);

   logic [15:0] x_r, y_r, w_r, h_r;
   logic [23:0] color_r, key_r;
   logic [1:0]  mode_r;
   logic        swap_pending, pp, err;

   state_t state, state_nx;

   logic [15:0]       w_eff, h_eff, col, row;
   logic [23:0]       color_l, key_l;
   logic [1:0]        mode_l;
   logic [BAW-1:0]    stride_l, idx, row_idx, rd_addr;
   logic [ADDR_W-1:0] line_addr, draw_base;
   logic [23:0]       rd_data, pixel;
   logic [31:0]       rdata_nx;
   logic              advance, skip, last_col, last_row, copy_l;

   logic reg_wr, ctrl_wr, start_req, swap_req, buf_we;
   assign buf_we    = reg_we && reg_addr[BAW];
   assign reg_wr    = reg_we && !reg_addr[BAW];
   assign ctrl_wr   = reg_wr && (reg_addr[3:0] == REG_CTRL) && reg_be[0];
   assign start_req = ctrl_wr && reg_wdata[CTRL_START];
   assign swap_req  = ctrl_wr && reg_wdata[CTRL_SWAP];

   // Setup-time checks are evaluated on the live registers; SETUP latches the result.
   logic [16:0] room_w, room_h;
   logic [31:0] area;
   logic [15:0] clip_w, clip_h;
   logic        copy_r, setup_err;
   assign room_w    = 17'(H_DISP) - {1'b0, x_r};
   assign room_h    = 17'(V_DISP) - {1'b0, y_r};
   assign area      = 32'(w_r) * 32'(h_r);
   assign copy_r    = (mode_r == MODE_COPY) || (mode_r == MODE_KEY);
   assign setup_err = ({1'b0, x_r} >= 17'(H_DISP)) || ({1'b0, y_r} >= 17'(V_DISP)) ||
                      (w_r == 16'd0) || (h_r == 16'd0) ||
                      (copy_r && (area > 32'(BUF_DEPTH)));
   assign clip_w    = ({1'b0, w_r} > room_w) ? room_w[15:0] : w_r;
   assign clip_h    = ({1'b0, h_r} > room_h) ? room_h[15:0] : h_r;

   assign draw_base = pp ? FB0 : FB1;
   assign disp_base = pp ? FB1 : FB0;

   assign copy_l   = (mode_l == MODE_COPY) || (mode_l == MODE_KEY);
   assign pixel    = copy_l ? rd_data : color_l;
   assign skip     = (mode_l == MODE_KEY) && (rd_data == key_l);
   assign last_col = (col == w_eff - 16'd1);
   assign last_row = (row == h_eff - 16'd1);
   assign wr_addr  = line_addr + ADDR_W'(col);
   assign wr_data  = {pixel, 8'h00};

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= ST_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      busy     = 1'b1;
      done     = 1'b0;
      wr_valid = 1'b0;
      advance  = 1'b0;
      case (state)
         ST_IDLE: begin
            busy = 1'b0;
            if (start_req) state_nx = ST_SETUP;
         end
         ST_SETUP: state_nx = setup_err ? ST_DONE : ST_ROW;
         ST_ROW: begin
            wr_valid = !skip;
            advance  = skip || wr_ready;
            if (advance && last_col) state_nx = ST_NEXT_ROW;
         end
         ST_NEXT_ROW: state_nx = last_row ? ST_DONE : ST_ROW;
         ST_DONE: begin
            done     = 1'b1;
            state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // Read address leads the current pixel by one cycle to cover RAM latency.
   always_comb begin
      rd_addr = idx;
      case (state)
         ST_SETUP:    rd_addr = '0;
         ST_ROW:      if (advance && !last_col) rd_addr = idx + 1'b1;
         ST_NEXT_ROW: rd_addr = row_idx + stride_l;
         default:     ;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         w_eff     <= '0;
         h_eff     <= '0;
         col       <= '0;
         row       <= '0;
         color_l   <= '0;
         key_l     <= '0;
         mode_l    <= '0;
         stride_l  <= '0;
         idx       <= '0;
         row_idx   <= '0;
         line_addr <= '0;
         err       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: if (start_req) err <= 1'b0;
            ST_SETUP: begin
               err       <= setup_err;
               w_eff     <= clip_w;
               h_eff     <= clip_h;
               color_l   <= color_r;
               key_l     <= key_r;
               mode_l    <= mode_r;
               stride_l  <= w_r[BAW-1:0];
               col       <= '0;
               row       <= '0;
               idx       <= '0;
               row_idx   <= '0;
               line_addr <= ADDR_W'(32'(draw_base) + 32'(y_r) * 32'(H_DISP) + 32'(x_r));
            end
            ST_ROW: begin
               if (advance && !last_col) begin
                  col <= col + 16'd1;
                  idx <= idx + 1'b1;
               end
            end
            ST_NEXT_ROW: begin
               if (!last_row) begin
                  row       <= row + 16'd1;
                  col       <= '0;
                  row_idx   <= row_idx + stride_l;
                  idx       <= row_idx + stride_l;
                  line_addr <= line_addr + ADDR_W'(H_DISP);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         x_r          <= '0;
         y_r          <= '0;
         w_r          <= '0;
         h_r          <= '0;
         color_r      <= '0;
         key_r        <= '0;
         mode_r       <= '0;
         swap_pending <= 1'b0;
         pp           <= 1'b0;
      end else begin
         if (reg_wr) begin
            case (reg_addr[3:0])
               REG_X:     x_r     <= 16'(be_merge({16'h0, x_r}, reg_wdata, reg_be));
               REG_Y:     y_r     <= 16'(be_merge({16'h0, y_r}, reg_wdata, reg_be));
               REG_W:     w_r     <= 16'(be_merge({16'h0, w_r}, reg_wdata, reg_be));
               REG_H:     h_r     <= 16'(be_merge({16'h0, h_r}, reg_wdata, reg_be));
               REG_COLOR: color_r <= 24'(be_merge({8'h0, color_r}, reg_wdata, reg_be));
               REG_KEY:   key_r   <= 24'(be_merge({8'h0, key_r}, reg_wdata, reg_be));
               REG_CTRL:  if (reg_be[0]) mode_r <= reg_wdata[CTRL_MODE_LSB +: 2];
               default:   ;
            endcase
         end
         // A repeated request while pending changes nothing; the swap itself wins.
         if (vsync && swap_pending && !busy) begin
            pp           <= ~pp;
            swap_pending <= 1'b0;
         end else if (swap_req) begin
            swap_pending <= 1'b1;
         end
      end
   end

   always_comb begin
      rdata_nx = '0;
      if (!reg_addr[BAW]) begin
         case (reg_addr[3:0])
            REG_X:      rdata_nx = {16'h0, x_r};
            REG_Y:      rdata_nx = {16'h0, y_r};
            REG_W:      rdata_nx = {16'h0, w_r};
            REG_H:      rdata_nx = {16'h0, h_r};
            REG_COLOR:  rdata_nx = {8'h0, color_r};
            REG_KEY:    rdata_nx = {8'h0, key_r};
            REG_CTRL:   rdata_nx = {29'h0, mode_r, 1'b0};
            REG_STATUS: rdata_nx = {29'h0, swap_pending, err, busy};
            REG_PP:     rdata_nx = {31'h0, pp};
            default:    ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) reg_rdata <= '0;
      else       reg_rdata <= rdata_nx;
   end

   gpu_pixel_buf #(
      .DEPTH (BUF_DEPTH),
      .AW    (BAW)
   ) u_buf (
      .clk   (clk),
      .we    (buf_we),
      .waddr (reg_addr[BAW-1:0]),
      .wbe   (reg_be[2:0]),
      .wdata (reg_wdata[23:0]),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

endmodule
